mdu: RTL and testbench

Multiply/divide unit in the E stage of the pipelined CPU, downstream of the instruction decoder's bus. It takes one decoded HI/LO operation per cycle plus both operands, and runs mult/multu/div/divu with fixed multi-cycle latency. It holds the architectural HI and LO registers and serves mthi/mtlo writes. It raises `busy` so the hazard unit can stall any later HI/LO-touching instruction in D.

---
 rtl/mdu_pkg.sv | 23 ++
 rtl/mdu.sv | 129 ++++++++++++
 tb/tb_mdu.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/mdu_pkg.sv
// Shared op codes, default latencies and state encoding for the multiply/divide unit.
package mdu_pkg;
  localparam logic [3:0] MDU_NONE  = 4'd0;
  localparam logic [3:0] MDU_MULT  = 4'd1;
  localparam logic [3:0] MDU_MULTU = 4'd2;
  localparam logic [3:0] MDU_DIV   = 4'd3;
  localparam logic [3:0] MDU_DIVU  = 4'd4;
  localparam logic [3:0] MDU_MTHI  = 4'd5;
  localparam logic [3:0] MDU_MTLO  = 4'd6;
  localparam logic [3:0] MDU_MADD  = 4'd7;
  localparam logic [3:0] MDU_MADDU = 4'd8;
  localparam logic [3:0] MDU_MSUB  = 4'd9;
  localparam logic [3:0] MDU_MSUBU = 4'd10;

  localparam int MDU_MULT_LAT = 5;
  localparam int MDU_DIV_LAT  = 10;
  localparam int CNT_W        = 8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;
endpackage

// File: rtl/mdu.sv
// E-stage multiply/divide unit holding architectural HI/LO with fixed-latency busy.
// Optional MADD/MADDU/MSUB/MSUBU accumulate ops are built when MDU_MADD_EN is defined.
module mdu import mdu_pkg::*; #(
  parameter int MULT_LAT = MDU_MULT_LAT,
  parameter int DIV_LAT  = MDU_DIV_LAT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  op,
  input  logic        start,
  input  logic        flush,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);
  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [63:0]        pend_q, pend_d;
  logic               pend_wr_q, pend_wr_d;
  logic [31:0]        hi_q, hi_d, lo_q, lo_d;

  logic        signed_op, accept, div_by_zero, neg_a, neg_b;
  logic [63:0] a_ext, b_ext, prod;
  logic [31:0] abs_a, abs_b, q_mag, r_mag, quot, rem;

  assign signed_op = (op == MDU_MULT) || (op == MDU_DIV) ||
                     (op == MDU_MADD) || (op == MDU_MSUB);

  // Low 64 bits of the product of sign/zero-extended operands is the exact result.
  assign a_ext = {{32{signed_op & A[31]}}, A};
  assign b_ext = {{32{signed_op & B[31]}}, B};
  assign prod  = a_ext * b_ext;

  // Divide on magnitudes, then restore signs: quotient truncates toward zero,
  // remainder follows the dividend; 0x80000000 / -1 wraps back to 0x80000000.
  assign neg_a       = signed_op & A[31];
  assign neg_b       = signed_op & B[31];
  assign abs_a       = neg_a ? (~A + 32'd1) : A;
  assign abs_b       = neg_b ? (~B + 32'd1) : B;
  assign div_by_zero = (B == 32'd0);
  assign q_mag       = div_by_zero ? 32'd0 : (abs_a / abs_b);
  assign r_mag       = div_by_zero ? 32'd0 : (abs_a % abs_b);
  assign quot        = (neg_a ^ neg_b) ? (~q_mag + 32'd1) : q_mag;
  assign rem         = neg_a ? (~r_mag + 32'd1) : r_mag;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pend_d    = pend_q;
    pend_wr_d = pend_wr_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    accept    = start && !flush && (state_q == ST_IDLE);
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          case (op)
            MDU_MULT, MDU_MULTU: begin
              state_d   = ST_RUN;
              cnt_d     = CNT_W'(MULT_LAT);
              pend_d    = prod;
              pend_wr_d = 1'b1;
            end
            MDU_DIV, MDU_DIVU: begin
              state_d   = ST_RUN;
              cnt_d     = CNT_W'(DIV_LAT);
              pend_d    = {rem, quot};
              pend_wr_d = !div_by_zero;
            end
            MDU_MTHI: hi_d = A;
            MDU_MTLO: lo_d = A;
`ifdef MDU_MADD_EN
            MDU_MADD, MDU_MADDU: begin
              state_d   = ST_RUN;
              cnt_d     = CNT_W'(MULT_LAT);
              pend_d    = {hi_q, lo_q} + prod;
              pend_wr_d = 1'b1;
            end
            MDU_MSUB, MDU_MSUBU: begin
              state_d   = ST_RUN;
              cnt_d     = CNT_W'(MULT_LAT);
              pend_d    = {hi_q, lo_q} - prod;
              pend_wr_d = 1'b1;
            end
`endif
            default: ;
          endcase
        end
      end
      ST_RUN: begin
        if (cnt_q == CNT_W'(1)) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          if (pend_wr_q) begin
            hi_d = pend_q[63:32];
            lo_d = pend_q[31:0];
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      pend_q    <= '0;
      pend_wr_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pend_q    <= pend_d;
      pend_wr_q <= pend_wr_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  assign busy = (state_q == ST_RUN);
  assign HI   = hi_q;
  assign LO   = lo_q;
endmodule

// File: tb/tb_mdu.sv
// Scoreboard bench for mdu: stimulus pushes model results, a negedge monitor checks them.
module tb_mdu;
  import mdu_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic [3:0]  op = 4'd0;
  logic [31:0] a = 32'd0;
  logic [31:0] b = 32'd0;
  logic        busy;
  logic [31:0] hi, lo;

  always #5 clk = ~clk;

  mdu dut (
    .clk(clk), .reset(reset), .op(op), .start(start), .flush(flush),
    .A(a), .B(b), .busy(busy), .HI(hi), .LO(lo)
  );

  typedef struct {
    int          lat;
    logic [3:0]  op;
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        cur;
  int          total = 0;
  int          bad = 0;
  int          seen = 0;
  bit          active = 0;
  bit          lat0_pend = 0;
  bit          rst_chk = 0;
  logic [31:0] hi_m = 32'd0;
  logic [31:0] lo_m = 32'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  // Reference model: plain 64-bit arithmetic on the architectural HI/LO pair.
  task automatic model_op(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                          output int lat);
    longint      sp, q, rm;
    logic [63:0] up;
    logic [63:0] acc;
    sp  = longint'($signed(x)) * longint'($signed(y));
    up  = {32'd0, x} * {32'd0, y};
    acc = {hi_m, lo_m};
    lat = 0;
    case (o)
      4'd1: begin {hi_m, lo_m} = sp; lat = 5; end
      4'd2: begin {hi_m, lo_m} = up; lat = 5; end
      4'd3: begin
        if (y != 32'd0) begin
          q    = longint'($signed(x)) / longint'($signed(y));
          rm   = longint'($signed(x)) % longint'($signed(y));
          lo_m = q[31:0];
          hi_m = rm[31:0];
        end
        lat = 10;
      end
      4'd4: begin
        if (y != 32'd0) begin
          lo_m = x / y;
          hi_m = x % y;
        end
        lat = 10;
      end
      4'd5: hi_m = x;
      4'd6: lo_m = x;
`ifdef MDU_MADD_EN
      4'd7:  begin {hi_m, lo_m} = acc + 64'(sp); lat = 5; end
      4'd8:  begin {hi_m, lo_m} = acc + up;      lat = 5; end
      4'd9:  begin {hi_m, lo_m} = acc - 64'(sp); lat = 5; end
      4'd10: begin {hi_m, lo_m} = acc - up;      lat = 5; end
`endif
      default: ;
    endcase
  endtask

  // Called just after a rising edge; waits for busy low, then presents one op for one edge.
  task automatic issue(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                       input bit fl);
    exp_t e;
    int   n = 0;
    while (busy && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (busy) begin
      total++;
      bad++;
      $display("FAIL issue_wait: busy=%b after %0d cycles, want 0", busy, n);
    end
    e.op = o;
    if (fl) e.lat = 0;
    else model_op(o, x, y, e.lat);
    e.hi = hi_m;
    e.lo = lo_m;
    exp_q.push_back(e);
    start = 1'b1; flush = fl; op = o; a = x; b = y;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    op = 4'($urandom); a = $urandom; b = $urandom;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'($urandom_range(0, 40)) - 32'd20;
      default: return $urandom;
    endcase
  endfunction

  always @(negedge clk) begin
    if (reset) begin
      active    = 0;
      lat0_pend = 0;
      rst_chk   = 1;
    end else begin
      if (rst_chk) begin
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_hi", hi, 32'd0);
        chk("reset_lo", lo, 32'd0);
        rst_chk = 0;
      end
      if (lat0_pend) begin
        chk($sformatf("op%0d_busy", cur.op), {31'd0, busy}, 32'd0);
        chk($sformatf("op%0d_hi", cur.op), hi, cur.hi);
        chk($sformatf("op%0d_lo", cur.op), lo, cur.lo);
        lat0_pend = 0;
      end
      if (active) begin
        if (busy) begin
          seen++;
          if (seen > cur.lat + 2) begin
            total++;
            bad++;
            $display("FAIL op%0d_timeout: busy for %0d cycles, want %0d", cur.op, seen, cur.lat);
            active = 0;
          end
        end else begin
          chk($sformatf("op%0d_lat", cur.op), 32'(seen), 32'(cur.lat));
          chk($sformatf("op%0d_hi", cur.op), hi, cur.hi);
          chk($sformatf("op%0d_lo", cur.op), lo, cur.lo);
          active = 0;
        end
      end
      if (start && busy) begin
        total++;
        bad++;
        $display("FAIL start_while_busy: start=1 busy=1, want busy=0");
      end
      if (start) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL scoreboard_empty: start seen with %0d entries, want >0", exp_q.size());
        end else begin
          cur = exp_q.pop_front();
          if (cur.lat == 0) lat0_pend = 1;
          else begin
            active = 1;
            seen   = 0;
          end
        end
      end
    end
  end

  initial begin
    int n;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    issue(MDU_MULT,  32'hFFFF_FFFE, 32'd3, 0);
    issue(MDU_MULTU, 32'hFFFF_FFFE, 32'd3, 0);
    issue(MDU_DIV,   32'hFFFF_FFF9, 32'd2, 0);
    issue(MDU_DIV,   32'd5,         32'd0, 0);
    issue(MDU_MTHI,  32'h1234,      32'd0, 0);
    issue(MDU_MTLO,  32'h5678,      32'd0, 0);
    issue(MDU_DIVU,  32'd100,       32'd7, 1);
    issue(MDU_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 0);

    // Flush during the run must not cancel the committed multiply.
    issue(MDU_MULT, 32'd7, 32'hFFFF_FFF7, 0);
    @(posedge clk); #1 flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;

    // Reset in the middle of a divide discards the pending result.
    issue(MDU_DIV, 32'd1000, 32'd3, 0);
    @(posedge clk); #1 reset = 1'b1;
    hi_m = 32'd0;
    lo_m = 32'd0;
    @(posedge clk); #1 reset = 1'b0;
    issue(MDU_MULT, 32'd12345, 32'd678, 0);

    issue(MDU_MTHI, 32'd0, 32'd0, 0);
    issue(MDU_MTLO, 32'hFFFF_FFFF, 32'd0, 0);
    issue(MDU_MADDU, 32'd1, 32'd1, 0);
    issue(MDU_MSUB, 32'hFFFF_FFFD, 32'd4, 0);
    issue(MDU_MADD, 32'h8000_0000, 32'h7FFF_FFFF, 0);

    for (int i = 0; i < 150; i++) begin
      issue(4'($urandom_range(0, 15)), pick(), pick(), ($urandom_range(0, 7) == 0));
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end
    end

    n = 0;
    while ((active || lat0_pend || exp_q.size() != 0) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (active || lat0_pend || exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: %0d entries left, want 0", exp_q.size());
    end
    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
